// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg
//   Shared definitions for the memory bus initiator: default widths and the
//   controller state encoding. No ports.
package mem_bus_master_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    WFLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master
//   Turns a valid/ready burst request into 1..2^LEN_W single-word bus beats
//   on the shared tri-state memory bus (CS, WE, ADDR, Mem_Bus). The memory
//   updates read data and commits writes on the falling clock edge, so a read
//   addressed in cycle k is captured on the rising edge that ends cycle k.
//
//   Ports
//     CLK, RST_N           clock, async active-low reset
//     req_valid/req_ready  burst request handshake (ready only in IDLE)
//     req_we               1 = write burst, 0 = read burst
//     req_addr, req_len    base word address, beats minus one
//     wdata_valid/_ready   write beat handshake, wdata = beat data
//     rsp_valid, rsp_rdata one-cycle read response strobe and word
//     done                 one-cycle pulse at command completion
//     CS, WE, ADDR         registered bus controls
//     Mem_Bus              driven only while CS & WE, else high-Z
//
//   state  | meaning
//   IDLE   | waiting for a request, bus released
//   READ   | one read beat per clock, capture previous beat's data
//   WRITE  | one write beat per accepted wdata, bubbles drop CS
//   WFLUSH | last write beat on the bus, pulse done next edge
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              done,
  output logic              CS,
  output logic              WE,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] Mem_Bus
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

  state_e              state_q, state_d;
  logic                cs_q, cs_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   nxt_addr_q, nxt_addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                done_q, done_d;

  logic last_beat;
  assign last_beat = (count_q == '0);

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      nxt_addr_q  <= '0;
      count_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      nxt_addr_q  <= nxt_addr_d;
      count_q     <= count_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_we ? WRITE : READ;
      READ:    if (last_beat) state_d = IDLE;
      WRITE:   if (wdata_valid && last_beat) state_d = WFLUSH;
      WFLUSH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    cs_d        = cs_q;
    we_d        = we_q;
    addr_d      = addr_q;
    nxt_addr_d  = nxt_addr_q;
    count_d     = count_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          count_d    = req_len;
          nxt_addr_d = req_addr;
          we_d       = 1'b0;
          // Reads put the first address on the bus at the accept edge;
          // writes wait for their first data beat.
          cs_d       = !req_we;
          if (!req_we) addr_d = req_addr;
        end
      end
      READ: begin
        rsp_rdata_d = Mem_Bus;
        rsp_valid_d = 1'b1;
        if (last_beat) begin
          cs_d   = 1'b0;
          done_d = 1'b1;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q - LEN_ONE;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          cs_d       = 1'b1;
          we_d       = 1'b1;
          addr_d     = nxt_addr_q;
          wdata_d    = wdata;
          nxt_addr_d = nxt_addr_q + ADDR_ONE;
          if (!last_beat) count_d = count_q - LEN_ONE;
        end else begin
          // Bubble: release the bus; WE follows CS so it never stands alone.
          cs_d = 1'b0;
          we_d = 1'b0;
        end
      end
      WFLUSH: begin
        cs_d   = 1'b0;
        we_d   = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign wdata_ready = (state_q == WRITE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign done        = done_q;
  assign CS          = cs_q;
  assign WE          = we_q;
  assign ADDR        = addr_q;

  // Drive only from registered controls, so reset releases the bus at once.
  assign Mem_Bus = (cs_q && we_q) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
module tb_mem_bus_master;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        done;
  logic        CS;
  logic        WE;
  logic [31:0] ADDR;
  wire  [31:0] Mem_Bus;

  int n_checks = 0;
  int n_errors = 0;
  int bad_we   = 0;

  mem_bus_master dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .done        (done),
    .CS          (CS),
    .WE          (WE),
    .ADDR        (ADDR),
    .Mem_Bus     (Mem_Bus)
  );

  always #5 CLK = ~CLK;

  // 128-word bus memory: commits writes and updates read data on falling edge
  logic [31:0] mem [128];
  logic [31:0] mem_rd;
  always @(negedge CLK) begin
    if (CS && WE) mem[ADDR[6:0]] <= Mem_Bus;
    mem_rd <= mem[ADDR[6:0]];
    if (WE && !CS) bad_we <= bad_we + 1;
  end
  assign Mem_Bus = (CS && !WE) ? mem_rd : 'z;

  // Reference contents of the memory as the bench intends them to be
  logic [31:0] ref_mem [128];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns at #1 after an edge.
  task automatic run_cmd(input logic we, input logic [31:0] a, input logic [2:0] l,
                         input logic [31:0] vpat, input bit rnd_v,
                         input logic [31:0] dbase, input bit rnd_d,
                         input bit hold, input int abort_after);
    int beats;
    int cyc;
    logic v;
    logic [31:0] d;
    logic [31:0] ea;
    check_eq("start_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_len   = l;
    @(posedge CLK); #1;
    if (!hold) req_valid = 1'b0;
    check_eq("acc_req_ready", 32'(req_ready), 32'd0);
    if (!we) begin
      check_eq("rd_acc_cs", 32'(CS), 32'd1);
      check_eq("rd_acc_we", 32'(WE), 32'd0);
      check_eq("rd_acc_addr", ADDR, a);
      for (int k = 0; k <= int'(l); k++) begin
        @(posedge CLK); #1;
        ea = a + 32'(k);
        check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rd_rdata", rsp_rdata, ref_mem[ea[6:0]]);
        check_eq("rd_done", 32'(done), (k == int'(l)) ? 32'd1 : 32'd0);
        if (k + 1 == abort_after) return;
        if (k < int'(l)) begin
          check_eq("rd_cs", 32'(CS), 32'd1);
          check_eq("rd_addr", ADDR, ea + 32'd1);
          check_eq("rd_busy", 32'(req_ready), 32'd0);
        end else begin
          check_eq("rd_end_cs", 32'(CS), 32'd0);
          check_eq("rd_end_ready", 32'(req_ready), 32'd1);
        end
      end
    end else begin
      check_eq("wr_acc_cs", 32'(CS), 32'd0);
      beats = 0;
      cyc   = 0;
      while (beats <= int'(l) && cyc < 64) begin
        v = rnd_v ? ((cyc >= 32) ? 1'b1 : 1'($urandom_range(0, 1))) : vpat[cyc[4:0]];
        d = rnd_d ? $urandom : dbase + 32'(beats);
        wdata_valid = v;
        wdata       = d;
        check_eq("wr_wdata_ready", 32'(wdata_ready), 32'd1);
        check_eq("wr_busy", 32'(req_ready), 32'd0);
        @(posedge CLK); #1;
        if (v) begin
          ea = a + 32'(beats);
          check_eq("wr_cs", 32'(CS), 32'd1);
          check_eq("wr_we", 32'(WE), 32'd1);
          check_eq("wr_addr", ADDR, ea);
          check_eq("wr_bus", Mem_Bus, d);
          ref_mem[ea[6:0]] = d;
          beats++;
        end else begin
          check_eq("wr_bubble_cs", 32'(CS), 32'd0);
          check_eq("wr_bubble_we", 32'(WE), 32'd0);
        end
        check_eq("wr_done_early", 32'(done), 32'd0);
        cyc++;
      end
      wdata_valid = 1'b0;
      check_eq("wr_beats", 32'(beats), 32'(int'(l) + 1));
      check_eq("wr_flush_wready", 32'(wdata_ready), 32'd0);
      @(posedge CLK); #1;
      check_eq("wr_done", 32'(done), 32'd1);
      check_eq("wr_end_cs", 32'(CS), 32'd0);
      check_eq("wr_end_we", 32'(WE), 32'd0);
      check_eq("wr_end_ready", 32'(req_ready), 32'd1);
    end
    if (!hold) begin
      @(posedge CLK); #1;
      check_eq("post_done", 32'(done), 32'd0);
      check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    CLK         = 1'b0;
    RST_N       = 1'b0;
    req_valid   = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;

    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_cs", 32'(CS), 32'd0);
    check_eq("rst_we", 32'(WE), 32'd0);
    check_eq("rst_addr", ADDR, 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_wdata_ready", 32'(wdata_ready), 32'd0);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Fill the whole memory through the DUT
    for (int b = 0; b < 16; b++)
      run_cmd(1'b1, 32'(b * 8), 3'd7, '1, 1'b0, 32'h0, 1'b1, 1'b0, -1);

    // Single write then read
    run_cmd(1'b1, 32'd5, 3'd0, '1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, -1);
    run_cmd(1'b0, 32'd5, 3'd0, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Burst write 1,2,3,4 then read back
    run_cmd(1'b1, 32'd10, 3'd3, '1, 1'b0, 32'd1, 1'b0, 1'b0, -1);
    run_cmd(1'b0, 32'd10, 3'd3, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Write bubbles 1,0,0,1
    run_cmd(1'b1, 32'd20, 3'd1, 32'b1001, 1'b0, 32'hCAFE0000, 1'b0, 1'b0, -1);
    run_cmd(1'b0, 32'd20, 3'd1, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // req_valid held high across alternating commands
    run_cmd(1'b1, 32'd30, 3'd2, '1, 1'b0, 32'h0, 1'b1, 1'b1, -1);
    run_cmd(1'b0, 32'd30, 3'd2, '0, 1'b0, 32'h0, 1'b0, 1'b1, -1);
    run_cmd(1'b1, 32'd40, 3'd1, '1, 1'b0, 32'h0, 1'b1, 1'b1, -1);
    run_cmd(1'b0, 32'd40, 3'd1, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Async reset in the middle of a read burst
    run_cmd(1'b0, 32'd0, 3'd7, '0, 1'b0, 32'h0, 1'b0, 1'b0, 3);
    #2 RST_N = 1'b0;
    #1;
    check_eq("arst_cs", 32'(CS), 32'd0);
    check_eq("arst_we", 32'(WE), 32'd0);
    check_eq("arst_addr", ADDR, 32'd0);
    check_eq("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("arst_done", 32'(done), 32'd0);
    check_eq("arst_ready", 32'(req_ready), 32'd1);
    repeat (2) begin
      @(posedge CLK); #1;
      check_eq("arst_hold_done", 32'(done), 32'd0);
      check_eq("arst_hold_cs", 32'(CS), 32'd0);
    end
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    check_eq("arst_rel_done", 32'(done), 32'd0);
    run_cmd(1'b0, 32'd0, 3'd7, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Address wrap
    run_cmd(1'b0, 32'hFFFF_FFFF, 3'd1, '0, 1'b0, 32'h0, 1'b0, 1'b0, -1);

    // Random mix
    for (int n = 0; n < 24; n++)
      run_cmd(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)),
              '0, 1'b1, 32'h0, 1'b1, 1'($urandom_range(0, 1)), -1);
    req_valid = 1'b0;
    @(posedge CLK); #1;

    check_eq("we_without_cs", 32'(bad_we), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
